// File: rtl/uart_apb_pkg.sv
// ============================================================================
// Module      : uart_apb_pkg
// Description : Shared constants for the UART command decoder: opcodes,
//               default frame marker and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_apb_pkg;

    localparam logic [7:0] OP_WRITE          = 8'h01;
    localparam logic [7:0] OP_READ           = 8'h02;
    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    localparam int         c_state_w   = 3;
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_opcode = 3'd1;
    localparam logic [2:0] c_st_addr   = 3'd2;
    localparam logic [2:0] c_st_data   = 3'd3;
    localparam logic [2:0] c_st_csum   = 3'd4;
    localparam logic [2:0] c_st_issue  = 3'd5;

endpackage

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module      : uart_cmd_decoder
// Description : Decodes SYNC/OPCODE/ADDR/DATA/CSUM byte frames from a UART
//               receiver into single APB read/write requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder
    import uart_apb_pkg::*;
#(
    parameter int         TIMEOUT_CLKS = 20000,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  i_data,
    input  logic        i_valid_data,
    output logic        o_req_valid,
    input  logic        i_req_ready,
    output logic        o_req_write,
    output logic [7:0]  o_req_addr,
    output logic [31:0] o_req_wdata,
    output logic        o_frame_err,
    output logic        o_busy
);

    localparam int               TMO_W      = $clog2(TIMEOUT_CLKS);
    localparam logic [TMO_W-1:0] c_tmo_max  = TMO_W'(TIMEOUT_CLKS - 1);

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;
    logic                 r_write;
    logic [7:0]           r_addr;
    logic [31:0]          r_wdata;
    logic [7:0]           r_csum;
    logic [1:0]           r_idx;
    logic [TMO_W-1:0]     r_tmo;
    logic                 r_frame_err;
    logic                 w_err;
    logic                 w_timed;
    logic                 w_tmo_hit;

    // A byte arriving in the expiry cycle wins over the timeout.
    assign w_timed   = (r_state == c_st_opcode) || (r_state == c_st_addr) ||
                       (r_state == c_st_data)   || (r_state == c_st_csum);
    assign w_tmo_hit = w_timed && !i_valid_data && (r_tmo == c_tmo_max);

    always_comb begin
        w_state_nxt = r_state;
        w_err       = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_valid_data && (i_data == SYNC_BYTE)) begin
                    w_state_nxt = c_st_opcode;
                end
            end
            c_st_opcode: begin
                if (i_valid_data) begin
                    if ((i_data == OP_WRITE) || (i_data == OP_READ)) begin
                        w_state_nxt = c_st_addr;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_addr: begin
                if (i_valid_data) begin
                    w_state_nxt = r_write ? c_st_data : c_st_csum;
                end
            end
            c_st_data: begin
                if (i_valid_data && (r_idx == 2'd3)) begin
                    w_state_nxt = c_st_csum;
                end
            end
            c_st_csum: begin
                if (i_valid_data) begin
                    if (i_data == r_csum) begin
                        w_state_nxt = c_st_issue;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = c_st_idle;
                    end
                end
            end
            c_st_issue: begin
                // Overrun bytes are dropped; the pending request is kept.
                w_err = i_valid_data;
                if (i_req_ready) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
        if (w_tmo_hit) begin
            w_err       = 1'b1;
            w_state_nxt = c_st_idle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_write     <= 1'b0;
            r_addr      <= 8'h00;
            r_wdata     <= 32'h0;
            r_csum      <= 8'h00;
            r_idx       <= 2'd0;
            r_tmo       <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_err;

            if (!w_timed || i_valid_data || w_tmo_hit) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + 1'b1;
            end

            if (i_valid_data) begin
                case (r_state)
                    c_st_opcode: begin
                        r_write <= (i_data == OP_WRITE);
                        r_csum  <= i_data;
                        r_wdata <= 32'h0;
                        r_idx   <= 2'd0;
                    end
                    c_st_addr: begin
                        r_addr <= i_data;
                        r_csum <= r_csum ^ i_data;
                    end
                    c_st_data: begin
                        r_wdata <= {r_wdata[23:0], i_data};
                        r_csum  <= r_csum ^ i_data;
                        r_idx   <= r_idx + 2'd1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_req_valid = (r_state == c_st_issue);
    assign o_req_write = r_write;
    assign o_req_addr  = r_addr;
    assign o_req_wdata = r_wdata;
    assign o_frame_err = r_frame_err;
    assign o_busy      = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_decoder.sv
// ============================================================================
// Module      : tb_uart_cmd_decoder
// Description : Scoreboard bench for uart_cmd_decoder with directed frames.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_decoder;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic [7:0]  i_data;
    logic        i_valid_data;
    logic        o_req_valid;
    logic        i_req_ready;
    logic        o_req_write;
    logic [7:0]  o_req_addr;
    logic [31:0] o_req_wdata;
    logic        o_frame_err;
    logic        o_busy;

    typedef struct packed {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } req_t;

    req_t exp_req_q[$];
    int   exp_err_q[$];
    int   n_pass;
    int   n_total;

    uart_cmd_decoder #(
        .TIMEOUT_CLKS (TMO),
        .SYNC_BYTE    (8'hA5)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .i_data       (i_data),
        .i_valid_data (i_valid_data),
        .o_req_valid  (o_req_valid),
        .i_req_ready  (i_req_ready),
        .o_req_write  (o_req_write),
        .o_req_addr   (o_req_addr),
        .o_req_wdata  (o_req_wdata),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents an output.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_frame_err) begin
                chk("frame_err_expected", 64'(exp_err_q.size() != 0), 64'd1);
                if (exp_err_q.size() != 0) void'(exp_err_q.pop_front());
            end
            if (o_req_valid) begin
                if (exp_req_q.size() == 0) begin
                    chk("req_expected", 64'd0, 64'd1);
                end else begin
                    chk("req_write", 64'(o_req_write), 64'(exp_req_q[0].write));
                    chk("req_addr",  64'(o_req_addr),  64'(exp_req_q[0].addr));
                    chk("req_wdata", 64'(o_req_wdata), 64'(exp_req_q[0].wdata));
                    if (i_req_ready) void'(exp_req_q.pop_front());
                end
            end
        end
    end

    // All driver tasks start and end at posedge + 1.
    task automatic send_byte(input logic [7:0] b);
        i_data       = b;
        i_valid_data = 1'b1;
        @(posedge clk);
        #1;
        i_valid_data = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic handshake();
        i_req_ready = 1'b1;
        @(posedge clk);
        #1;
        i_req_ready = 1'b0;
        chk("valid_drop_after_ready", 64'(o_req_valid), 64'd0);
    endtask

    initial begin
        n_pass       = 0;
        n_total      = 0;
        rst          = 1'b1;
        i_data       = 8'h00;
        i_valid_data = 1'b0;
        i_req_ready  = 1'b0;
        #1;
        chk("rst_outputs", {o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_frame_err, o_busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Write frame, request stalled 5 cycles.
        exp_req_q.push_back('{1'b1, 8'h10, 32'hDEADBEEF});
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("wr_valid_before_csum", 64'(o_req_valid), 64'd0);
        send_byte(8'h33);
        chk("wr_valid_latency", 64'(o_req_valid), 64'd1);
        idle(5);
        chk("wr_valid_held", 64'(o_req_valid), 64'd1);
        handshake();
        chk("wr_busy_after", 64'(o_busy), 64'd0);

        // Read frame.
        exp_req_q.push_back('{1'b0, 8'h3C, 32'h0});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C);
        chk("rd_valid_before_csum", 64'(o_req_valid), 64'd0);
        send_byte(8'h3E);
        chk("rd_valid_latency", 64'(o_req_valid), 64'd1);
        handshake();

        // Bad checksum.
        exp_err_q.push_back(1);
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h10);
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hFF);
        idle(2);
        chk("badcs_busy", 64'(o_busy), 64'd0);

        // Noise then bad opcode.
        send_byte(8'h55);
        chk("noise_ignored_busy", 64'(o_busy), 64'd0);
        send_byte(8'hA5);
        chk("sync_busy", 64'(o_busy), 64'd1);
        exp_err_q.push_back(2);
        send_byte(8'h07);
        idle(2);
        chk("badop_busy", 64'(o_busy), 64'd0);

        // Timeout, then a read frame still decodes.
        exp_err_q.push_back(3);
        send_byte(8'hA5); send_byte(8'h01);
        begin
            int n;
            n = 0;
            while (o_busy && n < 3 * TMO) begin
                idle(1);
                n++;
            end
        end
        chk("tmo_returns_idle", 64'(o_busy), 64'd0);
        idle(2);
        chk("tmo_err_seen", 64'(exp_err_q.size()), 64'd0);
        exp_req_q.push_back('{1'b0, 8'h3C, 32'h0});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h3E);
        chk("post_tmo_valid", 64'(o_req_valid), 64'd1);
        handshake();

        // Reset mid-frame: everything cleared, no error pulse.
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h42);
        rst = 1'b1;
        #2;
        chk("midrst_outputs", {o_req_valid, o_req_write, o_req_addr, o_req_wdata, o_frame_err, o_busy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // Overrun during ISSUE keeps the request.
        exp_req_q.push_back('{1'b0, 8'h3C, 32'h0});
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h3C); send_byte(8'h3E);
        exp_err_q.push_back(4);
        send_byte(8'h77);
        idle(2);
        chk("overrun_valid_kept", 64'(o_req_valid), 64'd1);
        handshake();

        idle(3);
        chk("req_queue_empty", 64'(exp_req_q.size()), 64'd0);
        chk("err_queue_empty", 64'(exp_err_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
